mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_pkg.sv | 16 +
 rtl/rr_arb2.sv | 15 +
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared defaults and FSM encoding for the two-port memory arbiter.
package mem_pkg;

    localparam int XPRLEN_DEF = 32;
    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;
    localparam int RD_LAT_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: ptr names the port that wins a tie.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a load port and a store port onto one single-port synchronous RAM,
// one transaction at a time, with round-robin tie breaking and range checking.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int XPRLEN = XPRLEN_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [XPRLEN-1:0] addr0,
    input  logic [XPRLEN-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);

    localparam logic [2:0] CNT_LAST = 3'(RD_LAT - 1);

    state_t            state_q, state_d;
    logic              rr_ptr;
    logic [1:0]        pick;
    logic              owner;
    logic              lat_we;
    logic              lat_oor;
    logic [2:0]        cnt_q;
    logic              finish;
    logic              sel_we;
    logic              sel_oor;
    logic [XPRLEN-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    function automatic logic out_of_range(input logic [XPRLEN-1:0] a);
        return (a >> ADDR_W) != '0;
    endfunction

    rr_arb2 u_rr (
        .req   ({req1, req0}),
        .ptr   (rr_ptr),
        .grant (pick)
    );

    assign sel_we    = pick[1] ? we1    : we0;
    assign sel_addr  = pick[1] ? addr1  : addr0;
    assign sel_wdata = pick[1] ? wdata1 : wdata0;
    assign sel_oor   = out_of_range(sel_addr);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Writes and range errors finish straight out of ACCESS; reads finish after RD_LAT wait cycles.
    always_comb begin
        state_d = state_q;
        finish  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (|pick) state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                finish  = lat_we | lat_oor;
                state_d = finish ? ST_DONE : ST_WAIT;
            end
            ST_WAIT: begin
                finish = (cnt_q == CNT_LAST);
                if (finish) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr      <= 1'b0;
            owner       <= 1'b0;
            lat_we      <= 1'b0;
            lat_oor     <= 1'b0;
            cnt_q       <= '0;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            done0       <= 1'b0;
            done1       <= 1'b0;
            err0        <= 1'b0;
            err1        <= 1'b0;
            rdata       <= '0;
            ram_address <= '0;
            ram_data    <= '0;
            ram_wren    <= 1'b0;
        end else begin
            ram_wren <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            err0     <= 1'b0;
            err1     <= 1'b0;
            if (finish) begin
                done0 <= ~owner;
                done1 <= owner;
                err0  <= ~owner & lat_oor;
                err1  <= owner & lat_oor;
            end
            // RAM port is loaded on the IDLE->ACCESS edge so it is stable for all of ACCESS and WAIT.
            unique case (state_q)
                ST_IDLE: begin
                    if (|pick) begin
                        owner       <= pick[1];
                        lat_we      <= sel_we;
                        lat_oor     <= sel_oor;
                        gnt0        <= pick[0];
                        gnt1        <= pick[1];
                        ram_address <= sel_addr[ADDR_W-1:0];
                        ram_data    <= sel_wdata;
                        ram_wren    <= sel_we & ~sel_oor;
                    end
                end
                ST_ACCESS: begin
                    cnt_q <= '0;
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q + 3'd1;
                    if (finish) rdata <= ram_q;
                end
                ST_DONE: begin
                    gnt0   <= 1'b0;
                    gnt1   <= 1'b0;
                    rr_ptr <= ~owner;
                end
                default: ;
            endcase
        end
    end

endmodule
